// File: rtl/sync_fifo_spram_fwft.sv
// First-word-fall-through synchronous FIFO built on two interleaved single-port RAM banks.
// The head word sits in an output register with a one-word prefetch behind it.

module single_ram_model #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                                    clk,
  input  logic                                    en,
  input  logic                                    we,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr,
  input  logic [WIDTH-1:0]                        wdata,
  output logic [WIDTH-1:0]                        rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

module sync_fifo_spram_fwft #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] used_cnt,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int   HALF   = DEPTH / 2;
  localparam int   AW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int   CW     = $clog2(DEPTH + 1);
  localparam logic AF_RST = (AF_LEVEL <= 0);
  localparam logic AE_RST = (AE_LEVEL >= 0);

  logic             out_vld_q, out_vld_d, pf_vld_q, pf_vld_d, hold_vld_q, hold_vld_d;
  logic [WIDTH-1:0] out_q, out_d, pf_q, pf_d, hold_q, hold_d;
  logic             rvld_q, rbank_q, wsel_q, wsel_d, rsel_q, rsel_d;
  logic [AW-1:0]    waddr_q [2];
  logic [AW-1:0]    waddr_d [2];
  logic [AW-1:0]    raddr_q [2];
  logic [AW-1:0]    raddr_d [2];
  logic [CW-1:0]    ram_cnt_q, ram_cnt_d, cnt_q, cnt_d;
  logic             full_q, empty_q, af_q, ae_q, ovf_q, udf_q;

  logic             push, pop, issue_rd, hold_front, hold_wr, din_front, din_pend, din_hold, din_wr;
  logic             din_bank;
  logic [1:0]       front_cnt, front_left;
  logic [1:0]       bank_wr, bank_rd;
  logic [AW-1:0]    bank_addr  [2];
  logic [WIDTH-1:0] bank_wdata [2];
  logic [WIDTH-1:0] bank_rdata [2];
  logic [WIDTH-1:0] ram_rdata;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(HALF - 1)) ? '0 : p + AW'(1);
  endfunction

  // Words enter the front (output/prefetch) strictly in age order: RAM, then holding reg, then din.
  always_comb begin
    push       = wr & ~full_q;
    pop        = rd & ~empty_q;
    front_cnt  = 2'(out_vld_q) + 2'(pf_vld_q) + 2'(rvld_q);
    front_left = front_cnt - 2'(pop);
    issue_rd   = (ram_cnt_q != '0) && (front_left <= 2'd1);
    hold_front = hold_vld_q && (ram_cnt_q == '0) && (front_left <= 2'd1);
    din_front  = push && (ram_cnt_q == '0) && ((front_left + 2'(hold_vld_q)) <= 2'd1);
    hold_wr    = hold_vld_q && !hold_front;
    din_bank   = wsel_q ^ hold_wr;
    din_pend   = push && !din_front;
    din_hold   = din_pend && issue_rd && (din_bank == rsel_q);
    din_wr     = din_pend && !din_hold;
    ram_rdata  = rbank_q ? bank_rdata[1] : bank_rdata[0];
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_d     = out_q;
    pf_vld_d  = pf_vld_q;
    pf_d      = pf_q;
    if (pop) begin
      out_vld_d = pf_vld_q;
      if (pf_vld_q) out_d = pf_q;
      pf_vld_d  = 1'b0;
    end
    if (rvld_q) begin
      if (!out_vld_d) begin out_d = ram_rdata; out_vld_d = 1'b1; end
      else            begin pf_d  = ram_rdata; pf_vld_d  = 1'b1; end
    end
    if (hold_front) begin
      if (!out_vld_d) begin out_d = hold_q; out_vld_d = 1'b1; end
      else            begin pf_d  = hold_q; pf_vld_d  = 1'b1; end
    end
    if (din_front) begin
      if (!out_vld_d) begin out_d = din; out_vld_d = 1'b1; end
      else            begin pf_d  = din; pf_vld_d  = 1'b1; end
    end
    hold_vld_d = din_hold;
    hold_d     = din_hold ? din : hold_q;
  end

  // A deferred write only ever targets the bank the read just left, so it always drains next cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_wr[b]    = (hold_wr && (int'(wsel_q) == b)) || (din_wr && (int'(din_bank) == b));
      bank_wdata[b] = (hold_wr && (int'(wsel_q) == b)) ? hold_q : din;
      bank_rd[b]    = issue_rd && (int'(rsel_q) == b);
      bank_addr[b]  = bank_wr[b] ? waddr_q[b] : raddr_q[b];
      waddr_d[b]    = bank_wr[b] ? ptr_inc(waddr_q[b]) : waddr_q[b];
      raddr_d[b]    = bank_rd[b] ? ptr_inc(raddr_q[b]) : raddr_q[b];
    end
    wsel_d    = wsel_q ^ hold_wr ^ din_wr;
    rsel_d    = rsel_q ^ issue_rd;
    ram_cnt_d = ram_cnt_q + CW'(hold_wr) + CW'(din_wr) - CW'(issue_rd);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    single_ram_model #(.WIDTH(WIDTH), .DEPTH(HALF)) u_bank (
      .clk   (clk),
      .en    (bank_wr[g] | bank_rd[g]),
      .we    (bank_wr[g]),
      .addr  (bank_addr[g]),
      .wdata (bank_wdata[g]),
      .rdata (bank_rdata[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      pf_vld_q   <= 1'b0;
      hold_vld_q <= 1'b0;
      rvld_q     <= 1'b0;
      rbank_q    <= 1'b0;
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        waddr_q[b] <= '0;
        raddr_q[b] <= '0;
      end
      ram_cnt_q  <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= AF_RST;
      ae_q       <= AE_RST;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      pf_vld_q   <= pf_vld_d;
      hold_vld_q <= hold_vld_d;
      rvld_q     <= issue_rd;
      rbank_q    <= rsel_q;
      wsel_q     <= wsel_d;
      rsel_q     <= rsel_d;
      for (int b = 0; b < 2; b++) begin
        waddr_q[b] <= waddr_d[b];
        raddr_q[b] <= raddr_d[b];
      end
      ram_cnt_q  <= ram_cnt_d;
      cnt_q      <= cnt_d;
      full_q     <= (cnt_d == CW'(DEPTH));
      empty_q    <= (cnt_d == '0);
      af_q       <= (cnt_d >= CW'(AF_LEVEL));
      ae_q       <= (cnt_d <= CW'(AE_LEVEL));
      ovf_q      <= wr & full_q;
      udf_q      <= rd & empty_q;
    end
  end

  always_ff @(posedge clk) begin
    pf_q   <= pf_d;
    hold_q <= hold_d;
  end

  assign dout         = out_q;
  assign used_cnt     = cnt_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_spram_fwft.sv
// Scoreboard bench for sync_fifo_spram_fwft: a reference queue tracks expected head words,
// count and status flags cycle by cycle.

module tb_sync_fifo_spram_fwft;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk, rst_n, wr, rd;
  logic [7:0]    din, dout;
  logic [CW-1:0] used_cnt;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int            errors = 0;
  int            checks = 0;
  int            m_cnt  = 0;
  logic [7:0]    sb [$];

  sync_fifo_spram_fwft #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wr),
    .din          (din),
    .rd           (rd),
    .dout         (dout),
    .used_cnt     (used_cnt),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at a falling edge; drives one cycle and checks the pop data, count and flags.
  task automatic do_cycle(input logic w, input logic [7:0] d, input logic r);
    logic       acc_w, acc_r, e_ovf, e_udf;
    logic [7:0] head;
    logic [5:0] exp_flags;
    acc_r = r && (m_cnt > 0);
    acc_w = w && (m_cnt < DEPTH);
    e_ovf = w && (m_cnt == DEPTH);
    e_udf = r && (m_cnt == 0);
    if (acc_r) begin
      head = sb.pop_front();
      checks++;
      if (dout !== head) begin
        errors++;
        $display("FAIL pop_data: dout=%02h expected %02h", dout, head);
      end
    end
    wr = w; din = d; rd = r;
    @(posedge clk);
    if (acc_w) sb.push_back(d);
    m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    checks++;
    if (used_cnt !== CW'(m_cnt)) begin
      errors++;
      $display("FAIL used_cnt: got %0d expected %0d", used_cnt, m_cnt);
    end
    exp_flags = {m_cnt == DEPTH, m_cnt == 0, m_cnt >= 14, m_cnt <= 2, e_ovf, e_udf};
    checks++;
    if ({full, empty, almost_full, almost_empty, overflow, underflow} !== exp_flags) begin
      errors++;
      $display("FAIL flags(full,empty,af,ae,ovf,udf): got %06b expected %06b",
               {full, empty, almost_full, almost_empty, overflow, underflow}, exp_flags);
    end
  endtask

  task automatic drain();
    while (m_cnt > 0) do_cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    checks++;
    if ({dout, used_cnt, full, empty, almost_full, almost_empty, overflow, underflow} !==
        {8'h00, CW'(0), 6'b010100}) begin
      errors++;
      $display("FAIL reset_state: dout=%02h cnt=%0d flags=%06b expected 00 0 010100", dout, used_cnt,
               {full, empty, almost_full, almost_empty, overflow, underflow});
    end
  endtask

  task automatic test_basic();
    do_cycle(1'b1, 8'h11, 1'b0);
    checks++;
    if (empty !== 1'b0 || dout !== 8'h11) begin
      errors++;
      $display("FAIL first_word_fallthrough: empty=%b dout=%02h expected 0 11", empty, dout);
    end
    do_cycle(1'b1, 8'h22, 1'b0);
    do_cycle(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_after_pops: got %b expected 1", empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 8'(8'h40 + i), 1'b0);
    checks++;
    if (full !== 1'b1 || used_cnt !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL full_at_depth: full=%b cnt=%0d expected 1 %0d", full, used_cnt, DEPTH);
    end
    do_cycle(1'b1, 8'hAA, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_single_pulse: got %b expected 0", overflow);
    end
    do_cycle(1'b1, 8'hBB, 1'b0);
    do_cycle(1'b1, 8'hCC, 1'b1);
    drain();
  endtask

  task automatic test_stream();
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin do_cycle(1'b1, v, 1'b0); v++; end
    for (int i = 0; i < 100; i++) begin do_cycle(1'b1, v, 1'b1); v++; end
    checks++;
    if (used_cnt !== CW'(8)) begin
      errors++;
      $display("FAIL stream_level: got %0d expected 8", used_cnt);
    end
    drain();
  endtask

  task automatic test_underflow();
    do_cycle(1'b1, 8'h5A, 1'b1);
    checks++;
    if (used_cnt !== CW'(1) || dout !== 8'h5A) begin
      errors++;
      $display("FAIL underflow_write: cnt=%0d dout=%02h expected 1 5a", used_cnt, dout);
    end
    drain();
  endtask

  task automatic test_thresholds();
    for (int i = 0; i < 13; i++) do_cycle(1'b1, 8'(i * 3), 1'b0);
    checks++;
    if (almost_full !== 1'b0) begin
      errors++;
      $display("FAIL af_at_13: got %b expected 0", almost_full);
    end
    do_cycle(1'b1, 8'hE0, 1'b0);
    checks++;
    if (almost_full !== 1'b1) begin
      errors++;
      $display("FAIL af_at_14: got %b expected 1", almost_full);
    end
    while (m_cnt > 3) do_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (almost_empty !== 1'b0) begin
      errors++;
      $display("FAIL ae_at_3: got %b expected 0", almost_empty);
    end
    do_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL ae_at_2: got %b expected 1", almost_empty);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'(8'h90 + i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || used_cnt !== CW'(0)) begin
      errors++;
      $display("FAIL async_reset: empty=%b cnt=%0d expected 1 0", empty, used_cnt);
    end
    sb.delete();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(1'b1, 8'h77, 1'b0);
    checks++;
    if (dout !== 8'h77) begin
      errors++;
      $display("FAIL post_reset_write: dout=%02h expected 77", dout);
    end
    do_cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      do_cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50));
    drain();
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_overflow();
    test_stream();
    test_underflow();
    test_thresholds();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo_spram_fwft.md
SYNC_FIFO_SPRAM_FWFT -- requirements
Module: sync_fifo_spram_fwft

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, total capacity in words (even, >=4).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold in words.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold in words.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port wr  input  1  write request; din captured when accepted.
REQ-008 SHALL have port din  input  WIDTH  write data.
REQ-009 SHALL have port rd  input  1  pop request; acknowledges the word currently on dout.
REQ-010 SHALL have port dout  output  WIDTH  head-of-FIFO word, valid whenever empty=0 (first-word-fall-through).
REQ-011 SHALL have port used_cnt  output  $clog2(DEPTH+1)  stored word count, range 0..DEPTH inclusive.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  registered status flags.
REQ-013 SHALL have ports overflow, underflow  output  1 each  one-cycle error pulses.

Function
REQ-014 SHALL store words in two single_ram_model banks of DEPTH/2 entries each (even/odd address interleave), with 1-cycle read latency and one access per bank per cycle.
REQ-015 SHALL hold the head word in an output register plus a 1-entry prefetch register, so dout needs no RAM access in the rd cycle; total capacity (banks + registers) is exactly DEPTH.
REQ-016 SHALL accept a write iff wr=1 and full=0; SHALL accept a read iff rd=1 and empty=0.
REQ-017 SHALL, for wr with full=1, drop the write, leave state unchanged, and pulse overflow in the next cycle; rd in that same cycle is still accepted.
REQ-018 SHALL, for rd with empty=1, ignore it and pulse underflow in the next cycle; wr in that same cycle is still accepted.
REQ-019 SHALL update used_cnt: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither accepted.
REQ-020 SHALL assert full when used_cnt==DEPTH, empty when used_cnt==0, almost_full when used_cnt>=AF_LEVEL, almost_empty when used_cnt<=AE_LEVEL, all from registered count (no combinational path from wr/rd).
REQ-021 SHALL, when the output path has room, bypass din straight to the output/prefetch register; write to empty FIFO at edge N SHALL give empty=0 and dout=din after edge N.
REQ-022 SHALL, after accepted rd at edge N, present the next word on dout after edge N; back-to-back rd every cycle SHALL sustain one word per cycle with no bubble.
REQ-023 SHALL resolve bank conflicts (read-fetch and write targeting the same bank in one cycle) via a 1-word write-holding register drained on the next free bank cycle; data order SHALL be preserved.
REQ-024 SHALL wrap bank write/read pointers modulo DEPTH/2 independently per bank.
REQ-025 SHALL sustain simultaneous accepted wr and rd every cycle indefinitely at any fill level, without loss, duplication or reordering.
REQ-026 SHALL leave dout stable while empty=0 and rd=0.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear pointers, used_cnt, holding/prefetch valids and error pulses; dout=0, empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>0).
REQ-028 SHALL discard all content on reset mid-operation; RAM contents need not be cleared.
REQ-029 SHALL ignore wr/rd while rst_n is low and in the first edge it is sampled low.

Verification
REQ-030 Reset, write 0x11,0x22,0x33 on three edges, then rd every cycle -> dout 0x11 visible one edge after first write; pops return 0x11,0x22,0x33; empty=1 after third pop.
REQ-031 Fill 16 words with DEPTH=16, then wr=1 din=0xAA -> full=1, used_cnt=16, overflow pulses one cycle, 0xAA never appears on dout.
REQ-032 With 8 stored, wr and rd every cycle for 100 cycles with incrementing data -> used_cnt stays 8, read stream strictly incrementing, no bubble.
REQ-033 Empty FIFO, rd=1 and wr=1 din=0x5A same cycle -> underflow pulses, used_cnt=1, dout=0x5A.
REQ-034 Fill to 14 (AF_LEVEL=14), drain to 2 (AE_LEVEL=2) -> almost_full rises at count 14, almost_empty rises at count 2, exactly at those counts.
REQ-035 Assert rst_n low with 5 words stored mid-stream -> immediately empty=1, used_cnt=0; subsequent write 0x77 reads back as 0x77.
